// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// opcodes, FSM states and the datapath mode selector.
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  localparam logic [2:0] MDU_NOP   = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;
  localparam logic [2:0] MDU_NOP7  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the shared datapath: shift-add multiply step or
// restoring-division step over an {acc, shreg} double-width register.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  mode_t            mode,
  input  logic [XLEN-1:0]  acc,
  input  logic [XLEN-1:0]  shreg,
  input  logic [XLEN-1:0]  operand,
  output logic [XLEN-1:0]  acc_next,
  output logic [XLEN-1:0]  shreg_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          fits;

  always_comb begin
    sum    = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
    rem_sh = {acc, shreg[XLEN-1]};
    diff   = rem_sh - {1'b0, operand};
    // explicit compare (not borrow) keeps divide-by-zero on the all-ones path
    fits   = (rem_sh >= {1'b0, operand});
    if (mode == MODE_MUL) begin
      acc_next   = sum[XLEN:1];
      shreg_next = {sum[0], shreg[XLEN-1:1]};
    end else begin
      acc_next   = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      shreg_next = {shreg[XLEN-2:0], fits};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 32 iterations on
// magnitudes followed by a one-cycle sign fix and commit.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_t          state_reg, state_next;
  mode_t           mode_reg;
  logic [CW-1:0]   count_reg;
  logic [XLEN-1:0] acc_reg, shreg_reg, operand_reg;
  logic [XLEN-1:0] acc_next, shreg_next;
  logic [XLEN-1:0] hi_reg, lo_reg;
  logic            neg_hi_reg, neg_lo_reg, done_reg;
  logic            load, step_en, commit, mt_hi, mt_lo;

  logic            is_mul, is_signed, sign_diff;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] hi_res, lo_res;

  always_comb begin
    is_mul    = (op == MDU_MULT) || (op == MDU_MULTU);
    is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    sign_diff = is_signed && (rs[XLEN-1] ^ rt[XLEN-1]);
    a_mag     = (is_signed && rs[XLEN-1]) ? -rs : rs;
    b_mag     = (is_signed && rt[XLEN-1]) ? -rt : rt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    load       = 1'b0;
    step_en    = 1'b0;
    commit     = 1'b0;
    mt_hi      = 1'b0;
    mt_lo      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start && !flush) begin
          case (op)
            MDU_MTHI: mt_hi = 1'b1;
            MDU_MTLO: mt_lo = 1'b1;
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              load       = 1'b1;
              state_next = ST_RUN;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (flush) begin
          state_next = ST_IDLE;
        end else begin
          step_en = 1'b1;
          if (count_reg == LAST) state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        busy       = 1'b1;
        state_next = ST_IDLE;
        commit     = !flush;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  mdu_step #(.XLEN(XLEN)) u_step (
    .mode       (mode_reg),
    .acc        (acc_reg),
    .shreg      (shreg_reg),
    .operand    (operand_reg),
    .acc_next   (acc_next),
    .shreg_next (shreg_next)
  );

  // Sign fix: multiply negates the full product; divide fixes quotient and remainder separately.
  always_comb begin
    prod     = {acc_reg, shreg_reg};
    prod_fix = neg_lo_reg ? -prod : prod;
    if (mode_reg == MODE_MUL) begin
      hi_res = prod_fix[2*XLEN-1:XLEN];
      lo_res = prod_fix[XLEN-1:0];
    end else begin
      hi_res = neg_hi_reg ? -acc_reg : acc_reg;
      lo_res = neg_lo_reg ? -shreg_reg : shreg_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg    <= MODE_MUL;
      count_reg   <= '0;
      acc_reg     <= '0;
      shreg_reg   <= '0;
      operand_reg <= '0;
      neg_hi_reg  <= 1'b0;
      neg_lo_reg  <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= commit;
      if (load) begin
        mode_reg    <= is_mul ? MODE_MUL : MODE_DIV;
        count_reg   <= '0;
        acc_reg     <= '0;
        shreg_reg   <= is_mul ? b_mag : a_mag;
        operand_reg <= is_mul ? a_mag : b_mag;
        neg_lo_reg  <= sign_diff;
        neg_hi_reg  <= is_mul ? sign_diff : (is_signed && rs[XLEN-1]);
      end else if (step_en) begin
        acc_reg   <= acc_next;
        shreg_reg <= shreg_next;
        count_reg <= count_reg + CW'(1);
      end
      if (mt_hi) hi_reg <= rs;
      if (mt_lo) lo_reg <= rs;
      if (commit) begin
        hi_reg <= hi_res;
        lo_reg <= lo_res;
      end
    end
  end

  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, multi-cycle
// corner sequences, and random ops against an arithmetic reference model.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_total = 0;
  int n_pass  = 0;

  mdu_iter #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      MDU_MULT:  begin q = sa * sb; return q; end
      MDU_MULTU: begin u = {32'd0, a} * {32'd0, b}; return u; end
      MDU_DIVU:  begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Called at a negedge; waits (bounded) for done, counting busy cycles.
  task automatic wait_done(output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (busy) cyc++;
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int cyc;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0; op = MDU_NOP;
    wait_done(cyc, seen);
    check({name, " done"}, 64'(seen), 64'd1);
    check({name, " busy_cycles"}, 64'(cyc), 64'd33);
    check({name, " hi"}, 64'(hi), 64'(exp[63:32]));
    check({name, " lo"}, 64'(lo), 64'(exp[31:0]));
    $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h busy=%0d", o, a, b, hi, lo, cyc);
    @(negedge clk);
    check({name, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cyc;
    bit seen;
    int done_cnt;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    vecs[0] = '{"multu_max",   MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{"mult_neg",    MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{"div_neg",     MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"divu_zero",   MDU_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[4] = '{"div_ovf",     MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[5] = '{"divu_10_3",   MDU_DIVU,  32'd10,       32'd3,        32'd1,        32'd3};
    vecs[6] = '{"div_negzero", MDU_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'd1};
    vecs[7] = '{"mult_minsq",  MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{"div_negneg",  MDU_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3};
    vecs[9] = '{"multu_6_7",   MDU_MULTU, 32'd6,        32'd7,        32'd0,        32'd42};

    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});

    // MTHI then MTLO back to back
    @(negedge clk);
    start = 1'b1; op = MDU_MTHI; rs = 32'h12345678;
    @(posedge clk); #1;
    check("mthi hi", 64'(hi), 64'h12345678);
    check("mthi busy", 64'(busy), 64'd0);
    op = MDU_MTLO; rs = 32'h9ABCDEF0;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_NOP;
    check("mtlo lo", 64'(lo), 64'h9ABCDEF0);
    check("mtlo hi_kept", 64'(hi), 64'h12345678);
    check("mtlo busy", 64'(busy), 64'd0);
    check("mtlo done", 64'(done), 64'd0);
    $display("mthi/mtlo -> hi=%h lo=%h", hi, lo);

    // MTHI presented while busy must be ignored
    @(negedge clk);
    start = 1'b1; op = MDU_DIVU; rs = 32'd10; rt = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = MDU_MTHI; rs = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; op = MDU_NOP;
    wait_done(cyc, seen);
    check("busy_mthi done", 64'(seen), 64'd1);
    check("busy_mthi hi", 64'(hi), 64'd1);
    check("busy_mthi lo", 64'(lo), 64'd3);
    $display("divu 10/3 with mthi in run -> hi=%h lo=%h", hi, lo);

    // Flush at cycle 10 of a second DIVU
    @(negedge clk);
    start = 1'b1; op = MDU_DIVU; rs = 32'd20; rt = 32'd7;
    @(negedge clk);
    start = 1'b0; op = MDU_NOP;
    repeat (9) @(negedge clk);
    check("flush pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("flush no_done", 64'(done_cnt), 64'd0);
    check("flush hi", 64'(hi), 64'd1);
    check("flush lo", 64'(lo), 64'd3);
    $display("flushed divu -> hi=%h lo=%h done_cnt=%0d", hi, lo, done_cnt);

    // flush and start together in IDLE: request dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MDU_DIVU; rs = 32'd50; rt = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op = MDU_NOP;
    check("flush_start busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MDU_MTHI; rs = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op = MDU_NOP;
    check("flush_start hi", 64'(hi), 64'd1);
    $display("flush+start in idle -> busy=%0b hi=%h", busy, hi);

    // NOP opcodes ignored
    @(negedge clk);
    start = 1'b1; op = MDU_NOP7; rs = 32'h55555555;
    @(negedge clk);
    start = 1'b0; op = MDU_NOP;
    check("nop7 busy", 64'(busy), 64'd0);
    check("nop7 hi", 64'(hi), 64'd1);

    // Randomized ops against the model
    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h80000000;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb));
    end

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; op = MDU_MULTU; rs = 32'd123; rt = 32'd456;
    @(negedge clk);
    start = 1'b0; op = MDU_NOP;
    repeat (10) @(negedge clk);
    check("areset pre_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("areset busy", 64'(busy), 64'd0);
    check("areset done", 64'(done), 64'd0);
    check("areset hi", 64'(hi), 64'd0);
    check("areset lo", 64'(lo), 64'd0);
    $display("async reset mid-run -> busy=%0b hi=%h lo=%h", busy, hi, lo);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_reset_multu", MDU_MULTU, 32'd6, 32'd7, 64'd42);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit; the multi-cycle counterpart to the single-cycle integer ALU in the execute stage.
- Owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over 32 iterations, plus single-cycle MTHI/MTLO.
- The pipeline controller issues requests with start, stalls on busy, and reads hi/lo for MFHI/MFLO.

Parameters:
- XLEN, 32, operand/HI/LO width; iteration count equals XLEN.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request valid; sampled only when busy=0
- op  in  3  request opcode (package constants)
- rs  in  XLEN  operand A (dividend / multiplicand / MT source)
- rt  in  XLEN  operand B (divisor / multiplier)
- flush  in  1  synchronous abort of the in-flight operation
- busy  out  1  high while iterating; pipeline stalls on it
- done  out  1  one-cycle pulse when HI/LO receive a mul/div result
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration count=0, internal datapath=0.
- Opcodes:
  - MULT=3'd1, MULTU=3'd2, DIV=3'd3, DIVU=3'd4, MTHI=3'd5, MTLO=3'd6.
  - 3'd0 and 3'd7 are NOP: start is ignored.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start with MTHI: hi<=rs at that edge; stay IDLE; no busy, no done.
  - start with MTLO: lo<=rs at that edge; stay IDLE; no busy, no done.
  - start with mul/div: latch the magnitudes of rs/rt (signed ops take absolute value; unsigned ops take raw bits), latch the result sign flags, count<=0, go to RUN.
- RUN:
  - busy=1. One iteration per cycle.
  - After the 32nd iteration (count==31), go to FIN.
  - start is ignored while busy.
- FIN:
  - busy=1 for this cycle.
  - At the edge: apply the sign fix, write hi/lo, pulse done=1 for the next cycle, return to IDLE.
- Latency: start accepted at edge N -> busy high for cycles N+1..N+33 -> hi/lo valid and done=1 in cycle N+34.
- A new start is accepted in the same cycle done is high.
- Multiply:
  - Shift-add, 64-bit accumulator.
  - Result {hi,lo} = product. MULT negates the 64-bit product when the operand signs differ.
- Divide:
  - Restoring division; produces a 32-bit quotient and remainder.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign.
  - lo=quotient, hi=remainder.
- Division by zero: no exception; the natural restoring result is committed.
  - DIVU x/0 -> lo=32'hFFFFFFFF, hi=x.
  - Signed DIV by zero: apply the normal sign rule to the same magnitudes.
- Signed overflow: 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0, no flag.
- Flush:
  - flush=1 in RUN or FIN -> IDLE next edge; hi/lo unchanged; done stays 0.
  - flush in IDLE has no effect.
  - If flush and start are high together in IDLE, flush wins: the request is dropped.
- Reset mid-operation: immediate return to the reset values above; no partial write to hi/lo.

Decomposition:
- Shared package mdu_pkg:
  - opcode constants MDU_NOP..MDU_MTLO
  - state encodings for IDLE/RUN/FIN
  - XLEN default
- One natural sub-module, mdu_step: combinational single-iteration datapath.
  - Inputs: mode (mul/div), accumulator, operand.
  - Outputs: next accumulator, next shift register.
  - It keeps the FSM/register shell free of arithmetic.

Test Plan:
- MULTU rs=32'hFFFFFFFF, rt=32'hFFFFFFFF -> busy for 33 cycles, done pulse; hi=32'hFFFFFFFE, lo=32'h00000001.
- MULT rs=-3 (32'hFFFFFFFD), rt=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; DIV rs=-7, rt=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- DIVU rs=100, rt=0 -> lo=32'hFFFFFFFF, hi=100; DIV 32'h80000000 by 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- MTHI rs=32'h12345678 then MTLO rs=32'h9ABCDEF0 in consecutive cycles -> hi/lo updated on each edge, busy and done never assert.
- Busy/flush/start:
  - DIVU 10/3, start re-asserted with MTHI during RUN -> MTHI ignored; result hi=1, lo=3.
  - Second DIVU with flush at cycle 10 -> returns to IDLE, hi/lo keep 1/3, no done.
- Async reset:
  - rst asserted mid-RUN, between clock edges -> busy/done/hi/lo are 0 immediately.
  - After release, MULTU 6*7 -> lo=42, hi=0.
